// File: rtl/mem_arbiter.sv
// Two-port arbiter for a shared instruction/data memory: port 0 is the core, port 1 the loader/debug port.
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 so the owner of the previous access can keep the memory.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int PRIO_FIX = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
`ifdef MEM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);
    localparam int CW = 4;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_nxt;
    logic          last;
    logic          owner;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic          sel1;
    logic          start;
    logic          finish;

    // Winner if both request: fixed priority or the port that was not served last.
    always_comb begin
        sel1 = req1;
        if (req0 && req1)
            sel1 = (PRIO_FIX != 0) ? 1'b0 : (last == 1'b0);
`ifdef MEM_ARB_LOCK_EN
        if (last && req1 && lock1)
            sel1 = 1'b1;
        else if (!last && req0 && lock0)
            sel1 = 1'b0;
`endif
    end

    assign start  = (state == IDLE) && (req0 || req1);
    assign finish = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            cnt     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            mem_we  <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
            rdata   <= '0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_we <= 1'b0;
            if (start) begin
                owner   <= sel1;
                last    <= sel1;
                gnt0    <= !sel1;
                gnt1    <= sel1;
                mem_adr <= sel1 ? adr1 : adr0;
                mem_wd  <= sel1 ? wd1 : wd0;
                we_q    <= sel1 ? we1 : we0;
                // Write strobe only lives for the first access cycle.
                mem_we  <= sel1 ? we1 : we0;
                cnt     <= CW'(MEM_LAT - 1);
            end else if (finish) begin
                if (!we_q)
                    rdata <= mem_rd;
                done0 <= !owner;
                done1 <= owner;
            end else if (state == ACCESS) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (round-robin lat 1, fixed-prio lat 1, round-robin lat 3),
// a behavioural memory, and a scoreboard that matches every done pulse against queued expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0 [N], req1 [N], we0 [N], we1 [N];
    logic [31:0] adr0 [N], adr1 [N], wd0 [N], wd1 [N];
    logic        gnt0 [N], gnt1 [N], done0 [N], done1 [N], mem_we [N];
    logic [31:0] rdata [N], mem_adr [N], mem_wd [N], mem_rd [N], rd_c [N];
    logic [31:0] d1, d2;
`ifdef MEM_ARB_LOCK_EN
    logic        lock0 [N], lock1 [N];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT((g == 2) ? 3 : 1), .PRIO_FIX((g == 1) ? 1 : 0)) u_dut (
            .clk(clk), .reset(rst),
            .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
            .adr0(adr0[g]), .adr1(adr1[g]), .wd0(wd0[g]), .wd1(wd1[g]),
`ifdef MEM_ARB_LOCK_EN
            .lock0(lock0[g]), .lock1(lock1[g]),
`endif
            .gnt0(gnt0[g]), .gnt1(gnt1[g]), .done0(done0[g]), .done1(done1[g]),
            .rdata(rdata[g]), .mem_adr(mem_adr[g]), .mem_wd(mem_wd[g]),
            .mem_we(mem_we[g]), .mem_rd(mem_rd[g])
        );
    end

    // Memory model: untouched locations read as address ^ A5A50000.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < N; k++)
            if (mem_we[k] === 1'b1) mem[mem_adr[k]] = mem_wd[k];
        for (int k = 0; k < N; k++)
            rd_c[k] = rd_mem(mem_adr[k]);
    end

    // Latency-3 instance sees the read value through two extra register stages.
    always @(posedge clk) begin
        d1 <= rd_c[2];
        d2 <= d1;
    end

    always_comb begin
        mem_rd[0] = rd_c[0];
        mem_rd[1] = rd_c[1];
        mem_rd[2] = d2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    // Scoreboard
    typedef struct {
        int          k;
        logic        p;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } exp_t;

    exp_t sb [$];
    int   we_cnt [N];

    function automatic int find(input int k);
        foreach (sb[i]) if (sb[i].k == k) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                chkb("gnt_exclusive", gnt0[k] & gnt1[k], 1'b0);
                chkb("done_exclusive", done0[k] & done1[k], 1'b0);
                if (mem_we[k] === 1'b1) begin
                    we_cnt[k]++;
                    idx = find(k);
                    chkb("sb_we_expected", idx >= 0, 1'b1);
                    if (idx >= 0) begin
                        chk("mem_adr_on_we", mem_adr[k], sb[idx].a);
                        chk("mem_wd_on_we", mem_wd[k], sb[idx].d);
                    end
                end
                if (done0[k] === 1'b1 || done1[k] === 1'b1) begin
                    idx = find(k);
                    chkb("sb_done_expected", idx >= 0, 1'b1);
                    if (idx >= 0) begin
                        chkb("done_port", done1[k], sb[idx].p);
                        if (sb[idx].w) begin
                            chk("we_cycles_write", 32'(we_cnt[k]), 32'd1);
                        end else begin
                            chk("we_cycles_read", 32'(we_cnt[k]), 32'd0);
                            chk("rdata", rdata[k], sb[idx].e);
                        end
                        sb.delete(idx);
                    end
                    we_cnt[k] = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
            adr0[k] = '0; adr1[k] = '0; wd0[k] = '0; wd1[k] = '0;
`ifdef MEM_ARB_LOCK_EN
            lock0[k] = 0; lock1[k] = 0;
`endif
            we_cnt[k] = 0;
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ev(input int k, input logic p, input bit is_done, input string nm);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = is_done ? (p ? done1[k] : done0[k]) : (p ? gnt1[k] : gnt0[k]);
        end
        chkb(nm, seen, 1'b1);
    endtask

    task automatic next_grant(input int k, output logic p);
        bit seen = 0;
        p = 1'bx;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (gnt0[k] === 1'b1 || gnt1[k] === 1'b1) begin
                seen = 1;
                p = gnt1[k];
            end
        end
        chkb("grant_seen", seen, 1'b1);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 60 && find(k) >= 0; i++) @(negedge clk);
        chkb("sb_drained", find(k) >= 0, 1'b0);
    endtask

    task automatic txn(input int k, input logic p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e);
        sb.push_back('{k, p, w, a, d, e});
        @(posedge clk); #1;
        if (p) begin req1[k] = 1; we1[k] = w; adr1[k] = a; wd1[k] = d; end
        else   begin req0[k] = 1; we0[k] = w; adr0[k] = a; wd0[k] = d; end
        wait_ev(k, p, 0, "txn_gnt");
        req0[k] = 0; req1[k] = 0;
        wait_ev(k, p, 1, "txn_done");
    endtask

    // Both ports hold read requests; grant order must match ord (bit i = port of grant i).
    task automatic both_run(input int k, input logic [5:0] ord);
        logic p;
        for (int i = 0; i < 6; i++)
            sb.push_back('{k, ord[i], 1'b0, ord[i] ? 32'h80 : 32'h10, 32'h0,
                           ord[i] ? 32'h1234_5678 : 32'h2002_0005});
        @(posedge clk); #1;
        req0[k] = 1; we0[k] = 0; adr0[k] = 32'h10;
        req1[k] = 1; we1[k] = 0; adr1[k] = 32'h80;
        for (int i = 0; i < 6; i++) begin
            next_grant(k, p);
            chkb("grant_order", p, ord[i]);
        end
        req0[k] = 0; req1[k] = 0;
        drain(k);
    endtask

    typedef struct {
        logic        p;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t tv [6];

    initial begin
        logic p;
        tv[0] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0};
        tv[1] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF};
        tv[2] = '{1'b0, 1'b1, 32'h80, 32'h1234_5678, 32'h0};
        tv[3] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'h1234_5678};
        tv[4] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h2002_0005};
        tv[5] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'hA5A5_0044};
        mem[32'h10] = 32'h2002_0005;

        // Reset values
        rst = 1'b1;
        #12;
        chkb("rst_gnt0", gnt0[0], 1'b0);
        chkb("rst_done0", done0[0], 1'b0);
        chkb("rst_mem_we", mem_we[0], 1'b0);
        chk("rst_mem_adr", mem_adr[0], 32'h0);
        chk("rst_mem_wd", mem_wd[0], 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        do_reset();

        // First read: exact cycle timing
        sb.push_back('{0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h2002_0005});
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 0; adr0[0] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        chkb("t1_gnt0", gnt0[0], 1'b1);
        chkb("t1_gnt1", gnt1[0], 1'b0);
        chkb("t1_early_done", done0[0], 1'b0);
        chk("t1_mem_adr", mem_adr[0], 32'h10);
        req0[0] = 0;
        @(negedge clk);
        chkb("t1_done0", done0[0], 1'b1);
        chk("t1_rdata", rdata[0], 32'h2002_0005);
        chkb("t1_gnt1_idle", gnt1[0], 1'b0);

        // Table of single transactions, including write then read-back
        for (int i = 0; i < 6; i++)
            txn(0, tv[i].p, tv[i].w, tv[i].a, tv[i].d, tv[i].e);
        drain(0);
        chk("rdata_hold", rdata[0], 32'hA5A5_0044);

        // Both held: alternation vs fixed priority
        do_reset();
        both_run(0, 6'b101010);
        both_run(1, 6'b000000);

        // Latency 3: done 3 cycles after gnt, late req1 waits for IDLE
        do_reset();
        sb.push_back('{2, 1'b0, 1'b0, 32'h10, 32'h0, 32'h2002_0005});
        sb.push_back('{2, 1'b1, 1'b0, 32'h80, 32'h0, 32'h1234_5678});
        @(posedge clk); #1;
        req0[2] = 1; we0[2] = 0; adr0[2] = 32'h10;
        next_grant(2, p);
        chkb("t4_first_port", p, 1'b0);
        req0[2] = 0;
        req1[2] = 1; we1[2] = 0; adr1[2] = 32'h80;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chkb("t4_done_timing", done0[2], j == 3);
            chkb("t4_no_gnt1_in_access", gnt1[2], 1'b0);
        end
        @(negedge clk);
        chkb("t4_gnt1_after_idle", gnt1[2], 1'b1);
        req1[2] = 0;
        drain(2);

        // Reset during a write access
        do_reset();
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 1; adr0[0] = 32'h90; wd0[0] = 32'h55AA_55AA;
        @(posedge clk); #1;
        chkb("t5_we_started", mem_we[0], 1'b1);
        rst = 1'b1;
        req0[0] = 0;
        #1;
        chkb("t5_we_abort", mem_we[0], 1'b0);
        chkb("t5_gnt0_abort", gnt0[0], 1'b0);
        chkb("t5_done0_abort", done0[0], 1'b0);
        chkb("t5_done1_abort", done1[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chkb("t5_no_write", mem.exists(32'h90), 1'b0);
        chkb("t5_no_done", done0[0], 1'b0);
        sb.delete();
        we_cnt[0] = 0;
        sb.push_back('{0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h2002_0005});
        sb.push_back('{0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h1234_5678});
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 0; adr0[0] = 32'h10;
        req1[0] = 1; we1[0] = 0; adr1[0] = 32'h80;
        next_grant(0, p);
        chkb("t5_first_after_rst", p, 1'b0);
        req0[0] = 0;
        next_grant(0, p);
        chkb("t5_second_after_rst", p, 1'b1);
        req1[0] = 0;
        drain(0);

`ifdef MEM_ARB_LOCK_EN
        // Lock keeps port 1 on the memory until released
        do_reset();
        for (int i = 0; i < 6; i++)
            sb.push_back('{0, (i >= 1 && i <= 4), 1'b0, (i >= 1 && i <= 4) ? 32'h80 : 32'h10,
                           32'h0, (i >= 1 && i <= 4) ? 32'h1234_5678 : 32'h2002_0005});
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 0; adr0[0] = 32'h10;
        req1[0] = 1; we1[0] = 0; adr1[0] = 32'h80;
        next_grant(0, p);
        chkb("t6_g0", p, 1'b0);
        next_grant(0, p);
        chkb("t6_g1", p, 1'b1);
        lock1[0] = 1;
        for (int i = 0; i < 3; i++) begin
            next_grant(0, p);
            chkb("t6_locked", p, 1'b1);
        end
        lock1[0] = 0;
        next_grant(0, p);
        chkb("t6_released", p, 1'b0);
        req0[0] = 0; req1[0] = 0;
        drain(0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
